// File: rtl/hazard_unit.sv
// hazard_unit: ID-stage hazard detection and forwarding-select generation.
// Shadows the destination/write/load info of the instructions in EX, MEM and
// WB. It raises id_stall when an operand cannot be forwarded in time. It also
// drives the forwarding selects for the operands in ID and EX, and for the
// store data in MEM.
// Optional feature: define HAZ_STALL_COUNT_EN to build a saturating stall
// counter on stall_count. Without it, stall_count is tied to zero.
module hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pipe_hold,
    input  logic                  id_flush,
    input  logic [7:0]            id_signal_forwarding,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    output logic                  id_stall,
    output logic [1:0]            id_fwd_rs,
    output logic [1:0]            id_fwd_rt,
    output logic [1:0]            ex_fwd_rs,
    output logic [1:0]            ex_fwd_rt,
    output logic                  mem_fwd_rt,
    output logic [CNT_W-1:0]      stall_count
);

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // Forwarding select encoding shared by the ID and EX operand muxes
    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEM_ALU = 2'b01;
    localparam logic [1:0] FWD_WB_DATA = 2'b10;

    // Stage numbering used by the stall rule: ID=1, EX=2, MEM=3, WB=4
    localparam logic [3:0] STAGE_EX  = 4'd2;
    localparam logic [3:0] STAGE_MEM = 4'd3;

    // Shadow copies of the instructions downstream of ID
    reg_addr_t ex_rs;
    reg_addr_t ex_rt;
    reg_addr_t ex_dest;
    logic      ex_reg_write;
    logic      ex_mem_read;
    reg_addr_t mem_rt;
    reg_addr_t mem_dest;
    logic      mem_reg_write;
    logic      mem_mem_read;
    reg_addr_t wb_dest;
    logic      wb_reg_write;

    // Operand index 0 is rs, 1 is rt
    reg_addr_t  id_src [2];
    reg_addr_t  ex_src [2];
    logic [1:0] op_stall;
    logic [1:0] id_sel [2];
    logic [1:0] ex_sel [2];

    // A producer feeds a consumer register only when it really writes a
    // nonzero register; $0 is hardwired and never creates a dependency.
    function automatic logic prod_match(input logic rw, input reg_addr_t dest,
                                        input reg_addr_t src);
        return rw && (dest != '0) && (dest == src);
    endfunction

    // Earliest stage at which the operand is needed; bits are {ID,EX,MEM,WB}.
    // 0 means the operand is not needed at all.
    function automatic logic [2:0] need_stage(input logic [3:0] bits);
        logic [2:0] n;
        n = 3'd0;
        if (bits[3])      n = 3'd1;
        else if (bits[2]) n = 3'd2;
        else if (bits[1]) n = 3'd3;
        else if (bits[0]) n = 3'd4;
        return n;
    endfunction

    // A producer in stage p whose result is ready at the end of stage R
    // (EX for ALU ops, MEM for loads) is too late for a consumer needing the
    // value at stage N when p+N-1 <= R.
    function automatic logic too_late(input logic [2:0] n, input logic [3:0] p,
                                      input logic is_load);
        logic [3:0] ready;
        ready = is_load ? 4'd3 : 4'd2;
        return (n != 3'd0) && (({1'b0, n} + p - 4'd1) <= ready);
    endfunction

    assign id_src[0] = id_rs;
    assign id_src[1] = id_rt;
    assign ex_src[0] = ex_rs;
    assign ex_src[1] = ex_rt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            logic [3:0] need_bits;
            logic [2:0] need_n;
            logic       id_ex_hit;
            logic       id_mem_hit;
            logic       id_wb_hit;
            logic       ex_mem_hit;
            logic       ex_wb_hit;

            // rs uses the odd need bits, rt the even ones
            assign need_bits = {id_signal_forwarding[7-gi], id_signal_forwarding[5-gi],
                                id_signal_forwarding[3-gi], id_signal_forwarding[1-gi]};
            assign need_n    = need_stage(need_bits);

            assign id_ex_hit  = prod_match(ex_reg_write,  ex_dest,  id_src[gi]);
            assign id_mem_hit = prod_match(mem_reg_write, mem_dest, id_src[gi]);
            assign id_wb_hit  = prod_match(wb_reg_write,  wb_dest,  id_src[gi]);
            assign ex_mem_hit = prod_match(mem_reg_write, mem_dest, ex_src[gi]);
            assign ex_wb_hit  = prod_match(wb_reg_write,  wb_dest,  ex_src[gi]);

            // WB never stalls: the register file writes before it is read
            assign op_stall[gi] =
                (id_ex_hit  && too_late(need_n, STAGE_EX,  ex_mem_read)) ||
                (id_mem_hit && too_late(need_n, STAGE_MEM, mem_mem_read));

            // Youngest producer wins. A younger match that cannot forward yet
            // (EX, or a load in MEM) blocks older, stale sources.
            assign id_sel[gi] = (id_src[gi] == '0) ? FWD_REGFILE :
                                id_ex_hit          ? FWD_REGFILE :
                                id_mem_hit         ? (mem_mem_read ? FWD_REGFILE : FWD_MEM_ALU) :
                                id_wb_hit          ? FWD_WB_DATA : FWD_REGFILE;

            assign ex_sel[gi] = (ex_src[gi] == '0) ? FWD_REGFILE :
                                ex_mem_hit         ? (mem_mem_read ? FWD_REGFILE : FWD_MEM_ALU) :
                                ex_wb_hit          ? FWD_WB_DATA : FWD_REGFILE;
        end
    endgenerate

    assign id_stall   = |op_stall;
    assign id_fwd_rs  = id_sel[0];
    assign id_fwd_rt  = id_sel[1];
    assign ex_fwd_rs  = ex_sel[0];
    assign ex_fwd_rt  = ex_sel[1];
    assign mem_fwd_rt = prod_match(wb_reg_write, wb_dest, mem_rt);

    // Advance the shadow pipeline; a stalled or flushed ID enters EX as a bubble
    always_ff @(posedge clock) begin
        if (!reset) begin
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_dest       <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            mem_rt        <= '0;
            mem_dest      <= '0;
            mem_reg_write <= 1'b0;
            mem_mem_read  <= 1'b0;
            wb_dest       <= '0;
            wb_reg_write  <= 1'b0;
        end else if (!pipe_hold) begin
            wb_dest       <= mem_dest;
            wb_reg_write  <= mem_reg_write;
            mem_rt        <= ex_rt;
            mem_dest      <= ex_dest;
            mem_reg_write <= ex_reg_write;
            mem_mem_read  <= ex_mem_read;
            if (id_flush || id_stall) begin
                ex_rs        <= '0;
                ex_rt        <= '0;
                ex_dest      <= '0;
                ex_reg_write <= 1'b0;
                ex_mem_read  <= 1'b0;
            end else begin
                ex_rs        <= id_rs;
                ex_rt        <= id_rt;
                ex_dest      <= id_dest;
                ex_reg_write <= id_reg_write;
                ex_mem_read  <= id_mem_read;
            end
        end
    end

`ifdef HAZ_STALL_COUNT_EN
    logic [CNT_W-1:0] stall_cnt;

    // Count effective stall cycles, saturating at all-ones
    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (id_stall && !pipe_hold && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign stall_count = stall_cnt;
`else
    assign stall_count = '0;
`endif

endmodule
